// File: rtl/scan_pkg.sv
// Shared types for the scan crossbar: completion status, FSM states and the timeout read fill.
package scan_pkg;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_DECODE  = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam bit RDATA_TIMEOUT_FILL = '1;

  // Overrun only reports when nothing worse happened to the command.
  function automatic err_e err_fold(input err_e base, input logic overrun);
    if (base == ERR_OK && overrun) return ERR_OVERRUN;
    return base;
  endfunction

endpackage

// File: rtl/scan_xbar.sv
// Scan command crossbar: decodes one scan command per id_valid to one of NT targets.
// Optional target wait limit is enabled with SCAN_XBAR_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for id_valid, last result held on static_*
// ISSUE | one-cycle strobe to the selected target
// WAIT  | strobe done, waiting for tgt_ready of the selected target
// DONE  | result published, returns to IDLE
module scan_xbar
  import scan_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int NT      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             static_wen,
  input  logic             static_ren,
  input  logic [AW-1:0]    static_addr,
  input  logic [DW-1:0]    static_wdata,
  output logic [DW-1:0]    static_rdata,
  output logic             static_ready,
  output logic [1:0]       static_err,
  output logic [NT-1:0]    tgt_ren,
  output logic [NT-1:0]    tgt_wen,
  output logic [AW-$clog2(NT)-1:0] tgt_addr,
  output logic [DW-1:0]    tgt_wdata,
  input  logic [NT*DW-1:0] tgt_rdata,
  input  logic [NT-1:0]    tgt_ready
);

  localparam int SEL_W = $clog2(NT);
  localparam int TAW   = AW - SEL_W;

  if (NT < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("scan_xbar: NT must be >= 2 and TIMEOUT >= 1");
  end

  state_e             state_q, state_d;
  logic               cmd_wen_q, cmd_ren_q;
  logic [SEL_W-1:0]   sel_q;
  logic [TAW-1:0]     addr_q;
  logic [DW-1:0]      wdata_q;
  logic               ov_q;
  err_e               base_err_q;
  err_e               err_q;
  logic               ready_q;
  logic [DW-1:0]      rdata_q;

  logic [SEL_W-1:0]   in_sel;
  logic               accept;
  logic               dec_bad;
  logic               sel_ready;
  logic [DW-1:0]      sel_rdata;
  logic               timeout_hit;
  logic               finish;
  err_e               eff_base;

  assign in_sel    = static_addr[AW-1:TAW];
  assign accept    = (state_q == IDLE) && id_valid;
  assign dec_bad   = (static_wen && static_ren) || (32'(in_sel) >= 32'(NT));
  assign sel_ready = tgt_ready[sel_q];
  assign sel_rdata = tgt_rdata[sel_q*DW +: DW];

`ifdef SCAN_XBAR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                  to_cnt_q <= '0;
    else if (state_q == ISSUE) to_cnt_q <= '0;
    else if (state_q == WAIT)  to_cnt_q <= to_cnt_q + 1'b1;
  end

  // Fires on the WAIT cycle whose increment brings the count to TIMEOUT.
  assign timeout_hit = (state_q == WAIT) && !sel_ready && (to_cnt_q == TO_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (id_valid) begin
          if (dec_bad || !(static_wen || static_ren)) state_d = DONE;
          else                                        state_d = ISSUE;
        end
      end
      ISSUE:   state_d = sel_ready ? DONE : WAIT;
      WAIT:    state_d = (sel_ready || timeout_hit) ? DONE : WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign finish   = ((state_q == ISSUE) || (state_q == WAIT)) && (state_d == DONE);
  assign eff_base = timeout_hit ? ERR_TIMEOUT : base_err_q;

  always_comb begin
    tgt_wen = '0;
    tgt_ren = '0;
    if (state_q == ISSUE) begin
      if (cmd_wen_q) tgt_wen = NT'(1) << sel_q;
      if (cmd_ren_q) tgt_ren = NT'(1) << sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_wen_q  <= 1'b0;
      cmd_ren_q  <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ov_q       <= 1'b0;
      base_err_q <= ERR_OK;
      err_q      <= ERR_OK;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        cmd_wen_q  <= static_wen;
        cmd_ren_q  <= static_ren;
        sel_q      <= in_sel;
        addr_q     <= static_addr[TAW-1:0];
        wdata_q    <= static_wdata;
        ready_q    <= 1'b0;
        ov_q       <= 1'b0;
        base_err_q <= dec_bad ? ERR_DECODE : ERR_OK;
      end else if (id_valid) begin
        ov_q <= 1'b1;
      end

      // A strobe in the DONE cycle still counts against the command being reported.
      if (finish) begin
        ready_q <= 1'b1;
        err_q   <= err_fold(eff_base, ov_q || id_valid);
        if (timeout_hit) begin
          base_err_q <= ERR_TIMEOUT;
          rdata_q    <= {DW{RDATA_TIMEOUT_FILL}};
        end else if (cmd_ren_q) begin
          rdata_q <= sel_rdata;
        end
      end else if (state_q == DONE) begin
        ready_q <= 1'b1;
        err_q   <= err_fold(base_err_q, ov_q || id_valid);
      end
    end
  end

  assign tgt_addr     = addr_q;
  assign tgt_wdata    = wdata_q;
  assign static_rdata = rdata_q;
  assign static_ready = ready_q;
  assign static_err   = err_q;

endmodule
